dma_channel_arbiter: RTL and testbench

Four-channel front end for the single-channel DMAC. It holds a per-channel copy of the DMAC setup words and arbitrates among peripheral DMA requests, using fixed or rotating priority. For each winning channel it programs the DMAC through its REGW/REGSEL/Setup port, then passes that channel's request and acknowledge through until the DMAC signals EOP. It sits between the peripherals and CPU configuration writes on one side and the DMAC's DREQ/DACK/EOP/register port on the other.

---
 rtl/dma_channel_arbiter.sv | 151 +++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
// Four-channel front end for a single-channel DMAC: per-channel setup registers,
// fixed/rotating arbitration, DMAC programming sequence and DREQ/DACK/EOP pass-through.
module dma_channel_arbiter #(
    parameter int NCH = 4,
    parameter int DW  = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CFGW,
    input  logic [1:0]     CFGCH,
    input  logic [1:0]     CFGSEL,
    input  logic [DW-1:0]  CFGDATA,
    input  logic           PRIO_MODE,
    input  logic [NCH-1:0] CH_REQ,
    output logic [NCH-1:0] CH_ACK,
    output logic [NCH-1:0] CH_EOP,
    output logic           REGW,
    output logic [1:0]     REGSEL,
    output logic [DW-1:0]  Setup,
    output logic           DREQ,
    input  logic           DACK,
    input  logic           EOP,
    output logic           BUSY,
    output logic [1:0]     ACTIVE_CH
);

    typedef enum logic [2:0] {
        IDLE,
        PROG0,
        PROG1,
        PROG2,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [DW-1:0]  mode_reg  [NCH];
    logic [DW-1:0]  count_reg [NCH];
    logic [DW-1:0]  addr_reg  [NCH];
    logic [NCH-1:0] enable;
    logic [1:0]     ptr;

    logic [NCH-1:0] eligible;
    logic           any_eligible;
    logic [1:0]     winner;
    logic [1:0]     base;
    logic [1:0]     idx;
    logic           found;
    logic [NCH-1:0] grant_onehot;
    logic           cfg_allowed;

    // The granted channel's words are frozen so the DMAC sees a consistent setup.
    assign cfg_allowed = CFGW && !(BUSY && (CFGCH == ACTIVE_CH));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                mode_reg[i]  <= '0;
                count_reg[i] <= '0;
                addr_reg[i]  <= '0;
            end
            enable <= '0;
        end else if (cfg_allowed) begin
            case (CFGSEL)
                2'b00:   mode_reg[CFGCH]  <= CFGDATA;
                2'b01:   count_reg[CFGCH] <= CFGDATA;
                2'b10:   addr_reg[CFGCH]  <= CFGDATA;
                default: enable[CFGCH]    <= CFGDATA[0];
            endcase
        end
    end

    // Search starts at ptr in rotating mode, at channel 0 in fixed mode.
    always_comb begin
        eligible     = enable & CH_REQ;
        any_eligible = |eligible;
        base         = PRIO_MODE ? ptr : 2'd0;
        winner       = 2'd0;
        found        = 1'b0;
        idx          = 2'd0;
        for (int i = 0; i < NCH; i++) begin
            idx = base + 2'(i);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        grant_onehot[ACTIVE_CH] = 1'b1;
    end

    assign BUSY   = (state != IDLE);
    assign DREQ   = (state == RUN) && CH_REQ[ACTIVE_CH];
    assign CH_ACK = ((state == RUN) && DACK) ? grant_onehot : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            ACTIVE_CH <= 2'd0;
            REGW      <= 1'b0;
            REGSEL    <= 2'b00;
            Setup     <= '0;
            CH_EOP    <= '0;
        end else begin
            CH_EOP <= '0;
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        ACTIVE_CH <= winner;
                        REGW      <= 1'b1;
                        REGSEL    <= 2'b00;
                        Setup     <= mode_reg[winner];
                        state     <= PROG0;
                    end
                end
                PROG0: begin
                    REGSEL <= 2'b01;
                    Setup  <= count_reg[ACTIVE_CH];
                    state  <= PROG1;
                end
                PROG1: begin
                    REGSEL <= 2'b10;
                    Setup  <= addr_reg[ACTIVE_CH];
                    state  <= PROG2;
                end
                PROG2: begin
                    REGW   <= 1'b0;
                    REGSEL <= 2'b00;
                    Setup  <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    if (EOP) begin
                        CH_EOP <= grant_onehot;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= ACTIVE_CH + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed-vector bench for dma_channel_arbiter; expected values are hand-computed
// from the programming sequence and the arbitration rules.
module tb_dma_channel_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CFGW;
    logic [1:0]  CFGCH;
    logic [1:0]  CFGSEL;
    logic [15:0] CFGDATA;
    logic        PRIO_MODE;
    logic [3:0]  CH_REQ;
    logic [3:0]  CH_ACK;
    logic [3:0]  CH_EOP;
    logic        REGW;
    logic [1:0]  REGSEL;
    logic [15:0] Setup;
    logic        DREQ;
    logic        DACK;
    logic        EOP;
    logic        BUSY;
    logic [1:0]  ACTIVE_CH;

    int vectors     = 0;
    int miscompares = 0;

    dma_channel_arbiter #(.NCH(4), .DW(16)) dut (
        .CLK(CLK), .RST(RST), .CFGW(CFGW), .CFGCH(CFGCH), .CFGSEL(CFGSEL),
        .CFGDATA(CFGDATA), .PRIO_MODE(PRIO_MODE), .CH_REQ(CH_REQ),
        .CH_ACK(CH_ACK), .CH_EOP(CH_EOP), .REGW(REGW), .REGSEL(REGSEL),
        .Setup(Setup), .DREQ(DREQ), .DACK(DACK), .EOP(EOP), .BUSY(BUSY),
        .ACTIVE_CH(ACTIVE_CH)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] data);
        CFGW = 1'b1; CFGCH = ch; CFGSEL = sel; CFGDATA = data;
        tick();
        CFGW = 1'b0;
    endtask

    task automatic resetDut();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // Waits for PROG0, checks the three programming cycles, ends in the first RUN cycle.
    task automatic grantProg(input string tag, input logic [1:0] ch,
                             input logic [15:0] mode, input logic [15:0] cnt, input logic [15:0] addr);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(REGW === 1'b1 && REGSEL === 2'b00) && n < 20);
        if (n >= 20) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_ch"}, 32'(ACTIVE_CH), 32'(ch));
        checkOutput({tag, "_mode"}, 32'(Setup), 32'(mode));
        tick();
        checkOutput({tag, "_sel1"}, 32'({REGW, REGSEL}), 32'h5);
        checkOutput({tag, "_cnt"}, 32'(Setup), 32'(cnt));
        tick();
        checkOutput({tag, "_sel2"}, 32'({REGW, REGSEL}), 32'h6);
        checkOutput({tag, "_addr"}, 32'(Setup), 32'(addr));
        tick();
        checkOutput({tag, "_run_regw"}, 32'(REGW), 32'd0);
        checkOutput({tag, "_run_dreq"}, 32'(DREQ), 32'd1);
    endtask

    task automatic grantEnd(input string tag, input logic [1:0] ch);
        logic [3:0] onehot;
        onehot = 4'b0001 << ch;
        EOP = 1'b1;
        tick();
        EOP = 1'b0;
        checkOutput({tag, "_eop"}, 32'(CH_EOP), 32'(onehot));
        checkOutput({tag, "_done_dreq"}, 32'(DREQ), 32'd0);
        tick();
        checkOutput({tag, "_eop_clr"}, 32'(CH_EOP), 32'd0);
        checkOutput({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    task automatic grantCycle(input string tag, input logic [1:0] ch);
        grantProg(tag, ch, 16'h0, 16'h0, 16'h0);
        grantEnd(tag, ch);
    endtask

    initial begin
        RST = 1'b0; CFGW = 1'b0; CFGCH = 2'd0; CFGSEL = 2'd0; CFGDATA = 16'h0;
        PRIO_MODE = 1'b0; CH_REQ = 4'b0; DACK = 1'b0; EOP = 1'b0;
        #2;
        resetDut();
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_outs", 32'({REGW, REGSEL, Setup, DREQ, CH_ACK, CH_EOP, ACTIVE_CH}), 32'd0);

        // Single channel on ch1
        applyStimulus(2'd1, 2'b00, 16'h0091);
        applyStimulus(2'd1, 2'b01, 16'h0003);
        applyStimulus(2'd1, 2'b10, 16'h0001);
        applyStimulus(2'd1, 2'b11, 16'h0001);
        CH_REQ = 4'b0010;
        grantProg("single", 2'd1, 16'h0091, 16'h0003, 16'h0001);
        DACK = 1'b1;
        #1 checkOutput("single_ack_hi", 32'(CH_ACK), 32'h2);
        DACK = 1'b0;
        #1 checkOutput("single_ack_lo", 32'(CH_ACK), 32'h0);
        CH_REQ = 4'b0000;
        #1 checkOutput("single_req_drop", 32'(DREQ), 32'd0);
        tick();
        checkOutput("single_hold", 32'({BUSY, ACTIVE_CH}), 32'h5);
        CH_REQ = 4'b0010;
        #1 checkOutput("single_req_back", 32'(DREQ), 32'd1);
        CH_REQ = 4'b0000;
        grantEnd("single", 2'd1);

        // Fixed priority
        resetDut();
        PRIO_MODE = 1'b0;
        applyStimulus(2'd0, 2'b11, 16'h1);
        applyStimulus(2'd2, 2'b11, 16'h1);
        applyStimulus(2'd3, 2'b11, 16'h1);
        CH_REQ = 4'b1101;
        grantCycle("fix_a", 2'd0);
        grantCycle("fix_b", 2'd0);
        CH_REQ = 4'b1100;
        grantCycle("fix_c", 2'd2);
        CH_REQ = 4'b1000;
        grantCycle("fix_d", 2'd3);
        CH_REQ = 4'b0000;

        // Rotating priority
        resetDut();
        PRIO_MODE = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(2'(i), 2'b11, 16'h1);
        CH_REQ = 4'b1111;
        grantCycle("rot_0", 2'd0);
        grantCycle("rot_1", 2'd1);
        grantCycle("rot_2", 2'd2);
        grantCycle("rot_3", 2'd3);
        grantCycle("rot_4", 2'd0);
        CH_REQ = 4'b0000;

        // No preemption, write to granted channel ignored
        resetDut();
        PRIO_MODE = 1'b0;
        applyStimulus(2'd2, 2'b01, 16'h0003);
        applyStimulus(2'd2, 2'b11, 16'h1);
        applyStimulus(2'd0, 2'b11, 16'h1);
        CH_REQ = 4'b0100;
        grantProg("np_a", 2'd2, 16'h0, 16'h0003, 16'h0);
        CH_REQ = 4'b0101;
        applyStimulus(2'd2, 2'b01, 16'h00FF);
        checkOutput("np_keep", 32'({BUSY, ACTIVE_CH}), 32'h6);
        tick();
        checkOutput("np_keep2", 32'({BUSY, DREQ, ACTIVE_CH}), 32'hE);
        grantEnd("np_a", 2'd2);
        grantCycle("np_b", 2'd0);
        CH_REQ = 4'b0100;
        grantProg("np_c", 2'd2, 16'h0, 16'h0003, 16'h0);
        CH_REQ = 4'b0000;
        grantEnd("np_c", 2'd2);

        // Disabled request and spurious EOP
        resetDut();
        CH_REQ = 4'b1000;
        tick();
        checkOutput("dis_busy1", 32'(BUSY), 32'd0);
        tick();
        checkOutput("dis_busy2", 32'(BUSY), 32'd0);
        EOP = 1'b1;
        tick();
        EOP = 1'b0;
        checkOutput("spur_eop", 32'({CH_EOP, BUSY}), 32'd0);
        tick();
        checkOutput("spur_eop2", 32'({CH_EOP, BUSY}), 32'd0);
        // Enable set in the same cycle as the request: eligible one cycle later
        applyStimulus(2'd3, 2'b11, 16'h1);
        checkOutput("same_cyc_busy", 32'(BUSY), 32'd0);
        tick();
        checkOutput("next_cyc_busy", 32'({BUSY, REGW, ACTIVE_CH}), 32'hF);
        CH_REQ = 4'b0000;

        // Reset in the middle of RUN
        resetDut();
        applyStimulus(2'd1, 2'b00, 16'h0091);
        applyStimulus(2'd1, 2'b11, 16'h1);
        CH_REQ = 4'b0010;
        grantProg("mid", 2'd1, 16'h0091, 16'h0, 16'h0);
        DACK = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("mid_rst_outs", 32'({REGW, REGSEL, Setup, DREQ, CH_ACK, CH_EOP, ACTIVE_CH}), 32'd0);
        checkOutput("mid_rst_busy", 32'(BUSY), 32'd0);
        DACK = 1'b0;
        tick();
        tick();
        checkOutput("mid_no_regrant", 32'(BUSY), 32'd0);
        applyStimulus(2'd1, 2'b11, 16'h1);
        grantProg("mid_recfg", 2'd1, 16'h0, 16'h0, 16'h0);
        CH_REQ = 4'b0000;
        grantEnd("mid_recfg", 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
